// File: rtl/bit_word_collector.sv
// ---------------------------------------------------------------------------
// bit_word_collector
//
// Assembles WIDTH consecutive serial bits (MSB first) from an upstream bit
// decoder into a parallel word and offers it to a consumer over a
// valid/acknowledge handshake. A partial word is dropped if the gap between
// two strobes inside a word reaches TIMEOUT cycles. A strobe that arrives
// while a finished word is still waiting sets a sticky overrun flag.
//
// Ports:
//   C       in   clock, rising edge
//   aRn     in   asynchronous active-low reset
//   R       in   bit strobe, one cycle high per received bit
//   Y       in   bit value, only meaningful while R=1
//   Ack     in   consumer accepts Q while V=1
//   Q       out  completed word, MSB = first bit received
//   V       out  Q valid
//   TO      out  one-cycle pulse: partial word discarded on timeout
//   OVF     out  sticky overrun flag, cleared by the next accepted word
//   StateQ  out  FSM state (IDLE=0, SHIFT=1, FULL=2)
// ---------------------------------------------------------------------------
module bit_word_collector #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255,
  parameter int TW      = 16
) (
  input  logic             C,
  input  logic             aRn,
  input  logic             R,
  input  logic             Y,
  input  logic             Ack,
  output logic [WIDTH-1:0] Q,
  output logic             V,
  output logic             TO,
  output logic             OVF,
  output logic [1:0]       StateQ
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]       state_reg, state_next;
  // Only WIDTH-1 bits are stored: the final bit of a word goes straight
  // into Q together with the stored ones.
  logic [WIDTH-2:0] sh_reg, sh_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [TW-1:0]    tmr_reg, tmr_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic             v_reg, v_next;
  logic             to_reg, to_next;
  logic             ovf_reg, ovf_next;

  logic [WIDTH-1:0] word_in;
  logic             last_bit;
  logic             tmr_expire;

  // Stored bits plus the incoming Y; only consumed on edges where R=1, so
  // an undefined Y while R=0 never reaches a register.
  assign word_in    = {sh_reg, Y};
  assign last_bit   = (cnt_reg == CW'(WIDTH - 1));
  assign tmr_expire = (tmr_reg == TW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge C or negedge aRn) begin
    if (!aRn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (R) state_next = SHIFT;
      end
      SHIFT: begin
        // A strobe on the would-be timeout edge takes priority.
        if (R) begin
          if (last_bit) state_next = FULL;
        end else if (tmr_expire) begin
          state_next = IDLE;
        end
      end
      FULL: begin
        if (Ack) state_next = R ? SHIFT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath next values (all registered below)
  always_comb begin
    sh_next  = sh_reg;
    cnt_next = cnt_reg;
    tmr_next = tmr_reg;
    q_next   = q_reg;
    v_next   = v_reg;
    to_next  = 1'b0;
    ovf_next = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (R) begin
          sh_next  = word_in[WIDTH-2:0];
          cnt_next = CW'(1);
          tmr_next = '0;
        end
      end
      SHIFT: begin
        if (R) begin
          sh_next  = word_in[WIDTH-2:0];
          tmr_next = '0;
          if (last_bit) begin
            q_next   = word_in;
            v_next   = 1'b1;
            cnt_next = '0;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end else if (tmr_expire) begin
          sh_next  = '0;
          cnt_next = '0;
          tmr_next = '0;
          to_next  = 1'b1;
        end else begin
          tmr_next = tmr_reg + TW'(1);
        end
      end
      FULL: begin
        if (Ack) begin
          v_next   = 1'b0;
          ovf_next = 1'b0;
          if (R) begin
            // Strobe on the accept edge starts the next word.
            sh_next  = word_in[WIDTH-2:0];
            cnt_next = CW'(1);
            tmr_next = '0;
          end
        end else if (R) begin
          // Bit dropped; Q must stay intact for the consumer.
          ovf_next = 1'b1;
        end
      end
      default: begin
        sh_next  = '0;
        cnt_next = '0;
        tmr_next = '0;
        v_next   = 1'b0;
      end
    endcase
  end

  // Datapath / output registers
  always_ff @(posedge C or negedge aRn) begin
    if (!aRn) begin
      sh_reg  <= '0;
      cnt_reg <= '0;
      tmr_reg <= '0;
      q_reg   <= '0;
      v_reg   <= 1'b0;
      to_reg  <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      sh_reg  <= sh_next;
      cnt_reg <= cnt_next;
      tmr_reg <= tmr_next;
      q_reg   <= q_next;
      v_reg   <= v_next;
      to_reg  <= to_next;
      ovf_reg <= ovf_next;
    end
  end

  assign Q      = q_reg;
  assign V      = v_reg;
  assign TO     = to_reg;
  assign OVF    = ovf_reg;
  assign StateQ = state_reg;

endmodule

// File: tb/tb_bit_word_collector.sv
// ---------------------------------------------------------------------------
// tb_bit_word_collector
//
// Self-checking bench for bit_word_collector (WIDTH=8, TIMEOUT=16).
// Expected words are queued when their bits are driven and compared when V
// rises. Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bit_word_collector;

  logic       C;
  logic       aRn;
  logic       R;
  logic       Y;
  logic       Ack;
  logic [7:0] Q;
  logic       V;
  logic       TO;
  logic       OVF;
  logic [1:0] StateQ;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       v_prev = 1'b0;

  bit_word_collector #(
    .WIDTH  (8),
    .TIMEOUT(16),
    .TW     (16)
  ) dut (
    .C     (C),
    .aRn   (aRn),
    .R     (R),
    .Y     (Y),
    .Ack   (Ack),
    .Q     (Q),
    .V     (V),
    .TO    (TO),
    .OVF   (OVF),
    .StateQ(StateQ)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Scoreboard: every rising V delivers the oldest queued word.
  always @(negedge C) begin
    if (V === 1'b1 && v_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_word", 32'(Q), 32'hFFFF_FFFF);
      end else begin
        chk("sb_word", 32'(Q), 32'(exp_q.pop_front()));
      end
    end
    v_prev = V;
  end

  // Called at a falling edge; returns at a falling edge.
  task automatic send_bit(input logic y, input int gap);
    R = 1'b1;
    Y = y;
    @(negedge C);
    R = 1'b0;
    Y = 1'bx;
    repeat (gap - 1) @(negedge C);
  endtask

  // Sends w[n-1:0] MSB first; returns one cycle after the last strobe edge.
  task automatic send_bits(input logic [7:0] w, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i], (i == 0) ? 1 : gap);
  endtask

  task automatic do_ack();
    Ack = 1'b1;
    @(negedge C);
    Ack = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_q"}, 32'(Q), 32'h0);
    chk({tag, "_v"}, 32'(V), 32'h0);
    chk({tag, "_to"}, 32'(TO), 32'h0);
    chk({tag, "_ovf"}, 32'(OVF), 32'h0);
    chk({tag, "_state"}, 32'(StateQ), 32'h0);
  endtask

  initial begin
    R   = 1'b0;
    Y   = 1'bx;
    Ack = 1'b0;
    aRn = 1'b0;
    #3;
    check_reset_outputs("reset");
    @(negedge C);
    aRn = 1'b1;
    @(negedge C);

    // Basic word 0xA5, strobes every 3rd cycle
    exp_q.push_back(8'hA5);
    send_bits(8'hA5, 8, 3);
    chk("a5_v", 32'(V), 32'h1);
    chk("a5_q", 32'(Q), 32'hA5);
    chk("a5_state", 32'(StateQ), 32'h2);
    do_ack();
    chk("a5_ack_v", 32'(V), 32'h0);
    chk("a5_ack_state", 32'(StateQ), 32'h0);
    chk("a5_ack_ovf", 32'(OVF), 32'h0);

    // Ack while V=0 is ignored
    do_ack();
    chk("idle_ack_v", 32'(V), 32'h0);
    chk("idle_ack_state", 32'(StateQ), 32'h0);

    // Timeout after 3 bits: TO pulses on the 16th idle edge only
    send_bits(8'h07, 3, 3);
    for (int i = 1; i <= 16; i++) begin
      @(negedge C);
      chk($sformatf("to_pulse_%0d", i), 32'(TO), (i == 16) ? 32'h1 : 32'h0);
    end
    chk("to_state", 32'(StateQ), 32'h0);
    chk("to_v", 32'(V), 32'h0);
    @(negedge C);
    chk("to_once", 32'(TO), 32'h0);
    exp_q.push_back(8'h3C);
    send_bits(8'h3C, 8, 3);
    chk("3c_q", 32'(Q), 32'h3C);
    do_ack();

    // Overrun while the word is held
    exp_q.push_back(8'hFF);
    send_bits(8'hFF, 8, 3);
    chk("ff_v", 32'(V), 32'h1);
    send_bit(1'b0, 3);
    chk("ovf_set", 32'(OVF), 32'h1);
    chk("ovf_q_held", 32'(Q), 32'hFF);
    chk("ovf_state", 32'(StateQ), 32'h2);
    chk("ovf_v", 32'(V), 32'h1);
    do_ack();
    chk("ovf_ack_v", 32'(V), 32'h0);
    chk("ovf_ack_clr", 32'(OVF), 32'h0);
    chk("ovf_ack_state", 32'(StateQ), 32'h0);

    // Ack on the same edge as the first bit of the next word
    exp_q.push_back(8'h81);
    send_bits(8'h81, 8, 3);
    chk("81_v", 32'(V), 32'h1);
    Ack = 1'b1;
    R   = 1'b1;
    Y   = 1'b1;
    @(negedge C);
    Ack = 1'b0;
    R   = 1'b0;
    Y   = 1'bx;
    chk("ackstrobe_v", 32'(V), 32'h0);
    chk("ackstrobe_state", 32'(StateQ), 32'h1);
    chk("ackstrobe_cnt", 32'(dut.cnt_reg), 32'h1);
    exp_q.push_back(8'h80);
    send_bits(8'h00, 7, 3);
    chk("80_v", 32'(V), 32'h1);
    chk("80_q", 32'(Q), 32'h80);
    do_ack();

    // Y undefined between strobes
    exp_q.push_back(8'h5A);
    send_bits(8'h5A, 8, 2);
    chk("5a_q", 32'(Q), 32'h5A);
    chk("5a_v", 32'(V), 32'h1);
    chk("5a_to", 32'(TO), 32'h0);
    chk("5a_ovf", 32'(OVF), 32'h0);
    chk("5a_state", 32'(StateQ), 32'h2);
    do_ack();

    // Asynchronous reset mid-word (Q still holds 0x5A before it)
    send_bits(8'h15, 5, 3);
    #2 aRn = 1'b0;
    #1 check_reset_outputs("rst_midword");
    @(negedge C);
    aRn = 1'b1;
    @(negedge C);

    // Asynchronous reset with V=1 and OVF=1
    exp_q.push_back(8'hC3);
    send_bits(8'hC3, 8, 3);
    send_bit(1'b1, 2);
    chk("c3_ovf", 32'(OVF), 32'h1);
    #2 aRn = 1'b0;
    #1 check_reset_outputs("rst_full");
    @(negedge C);
    aRn = 1'b1;
    @(negedge C);

    // Back-to-back strobes after reset
    exp_q.push_back(8'h96);
    send_bits(8'h96, 8, 1);
    chk("96_v", 32'(V), 32'h1);
    chk("96_q", 32'(Q), 32'h96);
    do_ack();
    chk("96_ack_v", 32'(V), 32'h0);

    repeat (3) @(negedge C);
    chk("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_word_collector.md
Name: bit_word_collector

Overview:
- Sits directly downstream of the serial S/D line decoder.
- Consumes that decoder's bit strobe R and bit value Y, and assembles WIDTH consecutive bits MSB-first into a parallel word.
- Presents the word to the consumer with a valid/acknowledge handshake.
- Aborts partial words on an inter-bit timeout and flags overrun when a new bit arrives while a completed word is still unacknowledged.

Parameters:
- WIDTH, 8: bits per word; legal range 2..32.
- TIMEOUT, 255: max C cycles allowed between consecutive R strobes inside a word; legal range 2..65535.
- TW, 16: timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- C  in  1  clock, all state updates on rising edge
- aRn  in  1  reset, asynchronous, active-low
- R  in  1  bit strobe from decoder, one-cycle high per received bit
- Y  in  1  received bit value, meaningful only when R=1 (may be X otherwise)
- Ack  in  1  consumer accepts Q when V=1
- Q  out  WIDTH  completed word, MSB = first bit received
- V  out  1  Q valid
- TO  out  1  one-cycle pulse, partial word discarded on timeout
- OVF  out  1  sticky overrun flag
- StateQ  out  2  current FSM state (debug)

Behaviour:
- One clock C; reset aRn is asynchronous, active-low.
- Reset (aRn=0, asynchronous, takes effect immediately):
  - state=IDLE; shift register, bit count, timeout counter = 0
  - Q=0, V=0, TO=0, OVF=0
  - Reset asserted mid-word or with V=1 drops everything; no word is delivered.
- Y is never sampled when R=0; X on Y with R=0 must not propagate to any register.
- States (StateQ encoding): IDLE=0, SHIFT=1, FULL=2; 3 unused, recovers to IDLE.
- IDLE:
  - R=1 → sh={sh[WIDTH-2:0],Y}, cnt=1, tmr=0, go SHIFT.
- SHIFT:
  - R=1 → shift Y in, cnt+1, tmr=0.
  - If this was bit number WIDTH: Q←completed word (including this Y), V=1, cnt=0, go FULL. V rises in the cycle after the WIDTH-th strobe edge, i.e. latency 1 cycle.
  - R=0 → tmr+1. When tmr reaches TIMEOUT-1 with R=0, at that edge: go IDLE, cnt=0, TO=1 for exactly one cycle.
  - Q and V are unaffected by a timeout.
  - A strobe arriving on the same edge that would time out wins: it is shifted in and no timeout occurs.
- FULL (V=1, Q stable and held until accepted):
  - Ack=1, R=0 → V=0, go IDLE.
  - Ack=1, R=1 → V=0; Y becomes bit 1 of the next word (cnt=1, tmr=0); go SHIFT.
  - Ack=0, R=1 → overrun: OVF=1; bit discarded; Q unchanged; stay FULL.
  - Ack=0, R=0 → hold. No timeout counting in FULL.
- OVF stays set until the next accepted word (edge with V=1 and Ack=1) or reset; clears on that edge.
- Ack with V=0 is ignored.
- WIDTH=2 boundary: second strobe completes the word; identical rules apply.
- All outputs are registered; no combinational path from inputs to outputs.
- Target implementation size: 120-250 lines.

Test Plan (WIDTH=8, TIMEOUT=16):
- Reset then 8 strobes (R=1 every 3rd cycle) with Y=1,0,1,0,0,1,0,1 → V=1 the cycle after the 8th strobe, Q=8'hA5, StateQ=2; Ack one cycle → V=0, StateQ=0, OVF=0.
- 3 strobes (Y=1,1,1) then R=0 for 16 cycles → TO high exactly 1 cycle on the 16th idle edge, StateQ=0, V=0; next 8 strobes of 8'h3C → Q=8'h3C (old bits gone).
- Complete word 8'hFF, hold Ack=0, send one strobe → OVF=1, Q stays 8'hFF, StateQ=2; Ack → V=0, OVF=0.
- Complete word 8'h81, assert Ack on the same cycle as the next strobe with Y=1 → V=0, StateQ=1, internal cnt=1; 7 more strobes of 0 → Q=8'h80.
- Drive Y=X whenever R=0 across a full 8'h5A word → Q=8'h5A, no X on any output.
- Assert aRn=0 between edges after 5 bits, and again with V=1 → Q=0, V=0, OVF=0, StateQ=0 immediately, without waiting for a clock edge.
